// File: rtl/periph_timer_regs_pkg.sv
// Shared constants for the CPU peripheral register block:
// bus address map, TCON bit positions and the address decoder.
package periph_pkg;

    localparam logic [31:0] ADDR_TH      = 32'h4000_0000;
    localparam logic [31:0] ADDR_TL      = 32'h4000_0004;
    localparam logic [31:0] ADDR_TCON    = 32'h4000_0008;
    localparam logic [31:0] ADDR_LED     = 32'h4000_000C;
    localparam logic [31:0] ADDR_DIGITS  = 32'h4000_0010;
    localparam logic [31:0] ADDR_SYSTICK = 32'h4000_0014;

    localparam int TCON_EN = 0;
    localparam int TCON_IE = 1;
    localparam int TCON_IS = 2;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_TH,
        SEL_TL,
        SEL_TCON,
        SEL_LED,
        SEL_DIGITS,
        SEL_SYSTICK
    } reg_sel_e;

    // Full 32-bit match; misaligned or foreign addresses map to nothing.
    function automatic reg_sel_e decode(input logic [31:0] addr);
        case (addr)
            ADDR_TH:      return SEL_TH;
            ADDR_TL:      return SEL_TL;
            ADDR_TCON:    return SEL_TCON;
            ADDR_LED:     return SEL_LED;
            ADDR_DIGITS:  return SEL_DIGITS;
            ADDR_SYSTICK: return SEL_SYSTICK;
            default:      return SEL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/periph_timer_regs_scan_clk_div.sv
// Scan clock divider: square wave with period 2*SCAN_DIV clk cycles.
// Ports: clk, reset_n (sync, active-low), oScanClk (registered).
import periph_pkg::*;

module scan_clk_div #(
    parameter int SCAN_DIV = 50000
) (
    input  logic clk,
    input  logic reset_n,
    output logic oScanClk
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          scan_q, scan_d;

    always_comb begin
        cnt_d  = cnt_q + CW'(1);
        scan_d = scan_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            scan_d = ~scan_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            scan_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            scan_q <= scan_d;
        end
    end

    assign oScanClk = scan_q;

endmodule

// File: rtl/periph_timer_regs.sv
// Memory-mapped timer/LED/display register block at 0x4000_0000.
// Ports: CPU load/store bus in, combinational oReadData out,
// oIRQ/oInterrupt (TCON status), oDigits, oLeds, oScanClk to the display.
import periph_pkg::*;

module periph_timer_regs #(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        iMemRead,
    input  logic        iMemWrite,
    input  logic [31:0] iAddr,
    input  logic [31:0] iWriteData,
    output logic [31:0] oReadData,
    output logic        oIRQ,
    output logic [15:0] oDigits,
    output logic        oInterrupt,
    output logic        oScanClk,
    output logic [7:0]  oLeds
);

    reg_sel_e sel;

    logic [31:0] th_q, th_d;
    logic [31:0] tl_q, tl_d;
    logic [2:0]  tcon_q, tcon_d;
    logic [7:0]  led_q, led_d;
    logic [15:0] dig_q, dig_d;
    logic [31:0] tick_q, tick_d;

    logic ovf;
    logic irq_set;

    assign sel     = decode(iAddr);
    assign ovf     = tcon_q[TCON_EN] && (tl_q == 32'hFFFF_FFFF);
    assign irq_set = ovf && tcon_q[TCON_IE];

    always_comb begin
        th_d   = th_q;
        tl_d   = tl_q;
        tcon_d = tcon_q;
        led_d  = led_q;
        dig_d  = dig_q;
        tick_d = tick_q + 32'd1;

        if (tcon_q[TCON_EN]) begin
            tl_d = ovf ? th_q : tl_q + 32'd1;
        end
        tcon_d[TCON_IS] = tcon_q[TCON_IS] | irq_set;

        // CPU writes override the timer, except that a same-cycle
        // overflow still sets the status so no interrupt is lost.
        if (iMemWrite) begin
            case (sel)
                SEL_TH:     th_d   = iWriteData;
                SEL_TL:     tl_d   = iWriteData;
                SEL_TCON:   tcon_d = {iWriteData[2] | irq_set,
                                      iWriteData[1:0]};
                SEL_LED:    led_d  = iWriteData[7:0];
                SEL_DIGITS: dig_d  = iWriteData[15:0];
                default:    ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            th_q   <= '0;
            tl_q   <= '0;
            tcon_q <= '0;
            led_q  <= '0;
            dig_q  <= '0;
            tick_q <= '0;
        end else begin
            th_q   <= th_d;
            tl_q   <= tl_d;
            tcon_q <= tcon_d;
            led_q  <= led_d;
            dig_q  <= dig_d;
            tick_q <= tick_d;
        end
    end

    always_comb begin
        oReadData = '0;
        if (iMemRead) begin
            case (sel)
                SEL_TH:      oReadData = th_q;
                SEL_TL:      oReadData = tl_q;
                SEL_TCON:    oReadData = {29'd0, tcon_q};
                SEL_LED:     oReadData = {24'd0, led_q};
                SEL_DIGITS:  oReadData = {16'd0, dig_q};
                SEL_SYSTICK: oReadData = tick_q;
                default:     oReadData = '0;
            endcase
        end
    end

    assign oIRQ       = tcon_q[TCON_IS];
    assign oInterrupt = tcon_q[TCON_IS];
    assign oDigits    = dig_q;
    assign oLeds      = led_q;

    scan_clk_div #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scan (
        .clk      (clk),
        .reset_n  (reset_n),
        .oScanClk (oScanClk)
    );

endmodule

// File: tb/tb_periph_timer_regs.sv
// Bench for periph_timer_regs: directed scenarios then random bus
// traffic, compared against a cycle-level register model.
import periph_pkg::*;

module tb_periph_timer_regs;

    localparam int SD = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        iMemRead = 1'b0;
    logic        iMemWrite = 1'b0;
    logic [31:0] iAddr = '0;
    logic [31:0] iWriteData = '0;
    logic [31:0] oReadData;
    logic        oIRQ;
    logic [15:0] oDigits;
    logic        oInterrupt;
    logic        oScanClk;
    logic [7:0]  oLeds;

    periph_timer_regs #(.SCAN_DIV(SD)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .iMemRead   (iMemRead),
        .iMemWrite  (iMemWrite),
        .iAddr      (iAddr),
        .iWriteData (iWriteData),
        .oReadData  (oReadData),
        .oIRQ       (oIRQ),
        .oDigits    (oDigits),
        .oInterrupt (oInterrupt),
        .oScanClk   (oScanClk),
        .oLeds      (oLeds)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_th, m_tl, m_tick;
    logic [2:0]  m_tcon;
    logic [7:0]  m_led;
    logic [15:0] m_dig;
    int          m_cyc;

    logic [31:0] r_th, r_tl, r_tcon, r_led, r_dig, r_tick;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        iAddr = a;
        iMemRead = 1'b1;
        #1;
        d = oReadData;
        iMemRead = 1'b0;
    endtask

    // Reference: what the registers hold after one clock edge,
    // derived directly from the register-map rules.
    task automatic model(input logic rst_n, input logic we,
                         input logic [31:0] a, input logic [31:0] d);
        logic        ovf, setis;
        logic [31:0] n_th, n_tl;
        logic [2:0]  n_tcon;
        logic [7:0]  n_led;
        logic [15:0] n_dig;
        if (!rst_n) begin
            m_th = 0; m_tl = 0; m_tcon = 0; m_led = 0;
            m_dig = 0; m_tick = 0; m_cyc = 0;
            return;
        end
        ovf    = m_tcon[0] && (m_tl == 32'hFFFF_FFFF);
        setis  = ovf && m_tcon[1];
        n_th   = m_th;
        n_tl   = !m_tcon[0] ? m_tl : (ovf ? m_th : m_tl + 1);
        n_tcon = {m_tcon[2] | setis, m_tcon[1:0]};
        n_led  = m_led;
        n_dig  = m_dig;
        if (we) begin
            if (a == ADDR_TH) n_th = d;
            if (a == ADDR_TL) n_tl = d;
            if (a == ADDR_TCON) n_tcon = {d[2] | setis, d[1:0]};
            if (a == ADDR_LED) n_led = d[7:0];
            if (a == ADDR_DIGITS) n_dig = d[15:0];
        end
        m_th = n_th; m_tl = n_tl; m_tcon = n_tcon;
        m_led = n_led; m_dig = n_dig;
        m_tick = m_tick + 1;
        m_cyc++;
    endtask

    task automatic chk_all();
        logic [31:0] d;
        logic [31:0] probe;
        probe = checks[0] ? 32'h4000_0018 : 32'h4000_0011;
        rd(ADDR_TH, r_th);        chk("rd_th", r_th, m_th);
        rd(ADDR_TL, r_tl);        chk("rd_tl", r_tl, m_tl);
        rd(ADDR_TCON, r_tcon);    chk("rd_tcon", r_tcon, {29'd0, m_tcon});
        rd(ADDR_LED, r_led);      chk("rd_led", r_led, {24'd0, m_led});
        rd(ADDR_DIGITS, r_dig);   chk("rd_dig", r_dig, {16'd0, m_dig});
        rd(ADDR_SYSTICK, r_tick); chk("rd_tick", r_tick, m_tick);
        rd(probe, d);             chk("rd_unmapped", d, 32'd0);
        iAddr = ADDR_SYSTICK;
        #1;
        chk("rd_idle", oReadData, 32'd0);
        chk("irq", {31'd0, oIRQ}, {31'd0, m_tcon[2]});
        chk("intr", {31'd0, oInterrupt}, {31'd0, m_tcon[2]});
        chk("digits", {16'd0, oDigits}, {16'd0, m_dig});
        chk("leds", {24'd0, oLeds}, {24'd0, m_led});
        chk("scan", {31'd0, oScanClk},
            32'((m_cyc / SD) % 2));
    endtask

    task automatic step(input logic rst_n, input logic we,
                        input logic [31:0] a, input logic [31:0] d);
        reset_n = rst_n;
        iMemWrite = we;
        iAddr = a;
        iWriteData = d;
        iMemRead = 1'b0;
        @(posedge clk);
        model(rst_n, we, a, d);
        #1;
        iMemWrite = 1'b0;
        chk_all();
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        step(1'b1, 1'b1, a, d);
    endtask

    logic [31:0] addrs [8];

    initial begin
        addrs = '{ADDR_TH, ADDR_TL, ADDR_TCON, ADDR_LED,
                  ADDR_DIGITS, ADDR_SYSTICK,
                  32'h4000_0018, 32'h4000_0006};

        step(1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b0, 1'b1, ADDR_LED, 32'hFF);
        chk("reset_tick", r_tick, 32'd0);
        chk("reset_led", r_led, 32'd0);

        for (int i = 0; i < 10; i++) idle();

        wr(ADDR_TH, 32'hFFFF_FFFC);
        wr(ADDR_TL, 32'hFFFF_FFFE);
        wr(ADDR_TCON, 32'd3);
        chk("tl_at_en", r_tl, 32'hFFFF_FFFE);
        idle();
        chk("tl_max", r_tl, 32'hFFFF_FFFF);
        idle();
        chk("tl_reload", r_tl, 32'hFFFF_FFFC);
        chk("irq_set", {31'd0, oIRQ}, 32'd1);
        chk("intr_set", {31'd0, oInterrupt}, 32'd1);
        wr(ADDR_TCON, 32'd3);
        chk("irq_clr", {31'd0, oIRQ}, 32'd0);

        wr(ADDR_TL, 32'hFFFF_FFFE);
        idle();
        wr(ADDR_TCON, 32'd3);
        chk("tcon_ovf_wr", r_tcon, 32'd7);
        chk("tl_ovf_wr", r_tl, 32'hFFFF_FFFC);
        wr(ADDR_TCON, 32'd3);
        wr(ADDR_TL, 32'hFFFF_FFFE);
        idle();
        wr(ADDR_TL, 32'd5);
        chk("tl_wr_wins", r_tl, 32'd5);
        chk("tcon_tl_wr", r_tcon, 32'd7);

        wr(ADDR_DIGITS, 32'h1234_ABCD);
        chk("digits_val", {16'd0, oDigits}, 32'h0000_ABCD);
        wr(ADDR_LED, 32'h0000_01FF);
        chk("leds_val", {24'd0, oLeds}, 32'h0000_00FF);
        wr(32'h4000_0018, 32'd7);
        wr(32'h4000_0011, 32'd7);
        wr(ADDR_SYSTICK, 32'd7);
        chk("dig_kept", r_dig, 32'h0000_ABCD);

        for (int i = 0; i < 400; i++) begin
            int k;
            logic [31:0] d;
            k = $urandom_range(0, 7);
            d = $urandom;
            if ((k == 0 || k == 1) && $urandom_range(0, 1) == 1)
                d = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            step($urandom_range(0, 99) != 0,
                 $urandom_range(0, 2) != 0, addrs[k], d);
        end

        wr(ADDR_TH, 32'hFFFF_FFFC);
        wr(ADDR_TL, 32'hFFFF_FFFE);
        wr(ADDR_TCON, 32'd3);
        idle();
        idle();
        chk("irq_pre_rst", {31'd0, oIRQ}, 32'd1);
        step(1'b0, 1'b1, ADDR_TL, 32'd9);
        chk("irq_rst", {31'd0, oIRQ}, 32'd0);
        chk("tl_rst", r_tl, 32'd0);
        chk("th_rst", r_th, 32'd0);
        chk("scan_rst", {31'd0, oScanClk}, 32'd0);
        idle();
        chk("tick_restart", r_tick, 32'd1);
        for (int i = 0; i < 9; i++) idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/periph_timer_regs.md
# periph_timer_regs

Memory-mapped peripheral register block on the MIPS CPU data bus, directly upstream of the seven-segment scanner. It holds the 16-bit display value, LED register, free-running system tick, and a reloadable interrupt timer. It also produces the scan clock and the interrupt-mode flag that drive the four-digit display driver. The CPU reaches it through the load/store path at base address 0x4000_0000.

## Interface
- SCAN_DIV, 50000: clk cycles per oScanClk half-period; must be ≥1.
- clk  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- iMemRead  in  1  CPU load strobe.
- iMemWrite  in  1  CPU store strobe.
- iAddr  in  32  byte address.
- iWriteData  in  32  store data.
- oReadData  out  32  load data; combinational.
- oIRQ  out  1  timer interrupt request to CPU; equals TCON[2].
- oDigits  out  16  display value; four hex nibbles, [15:12] leftmost; feeds scanner idata.
- oInterrupt  out  1  display interrupt-pattern select; equals TCON[2]; feeds scanner iInterrupt.
- oScanClk  out  1  registered square-wave scan clock; feeds scanner scan_clk.
- oLeds  out  8  LED register.

## Operation
- Register map, full 32-bit compare:
  - 0x4000_0000: TH, R/W, 32-bit, timer reload value.
  - 0x4000_0004: TL, R/W, 32-bit, timer count.
  - 0x4000_0008: TCON, R/W, 3-bit. Bit 0 is timer enable, bit 1 is IRQ enable, bit 2 is IRQ status. Upper read bits are 0.
  - 0x4000_000C: LED, R/W, 8-bit.
  - 0x4000_0010: DIGITS, R/W, 16-bit.
  - 0x4000_0014: SYSTICK, read-only, 32-bit.
- Any other address, including iAddr[1:0]≠0: reads return 0; writes are ignored.
- Write: when iMemWrite=1, the addressed register takes the low bits of iWriteData at the next edge. Writes to SYSTICK are ignored.
- Read: oReadData = register value when iMemRead=1 and the address is mapped; otherwise 0. Reads have no side effects.
- Timer, when TCON[0]=1:
  - If TL = 0xFFFF_FFFF, TL←TH, and TCON[2]←1 if TCON[1]=1.
  - Otherwise TL←TL+1.
  - When TCON[0]=0, TL holds.
- SYSTICK: increments every cycle and wraps at 2^32.
- IRQ clear: software writes TCON with bit 2 = 0.
- Simultaneous events:
  - CPU write to TL in the same cycle as an increment or reload: the write wins.
  - CPU write to TCON in the same cycle as an overflow: bits 1:0 take the written value; bit 2 = written bit 2 OR overflow-set. Set dominates, so no interrupt is lost.
  - Overflow in the same cycle as a TL write: TL takes the written value; status is still set if TCON[1]=1.
- Scan divider:
  - Counter counts 0..SCAN_DIV−1.
  - At SCAN_DIV−1 the counter returns to 0 and oScanClk toggles.
  - oScanClk period is 2·SCAN_DIV clk cycles.

## Timing
- Reset (reset_n=0 at an edge): TH, TL, TCON, LED, DIGITS, SYSTICK, and the scan counter go to 0; oScanClk=0; oIRQ=oInterrupt=0.
- Reset takes priority over every write and count in the same cycle.
- Reset asserted mid-operation aborts any pending overflow and drops oIRQ on the next edge.
- Write latency: the register is visible on oReadData and outputs one cycle after the write edge.
- Read latency: zero cycles, combinational from iAddr/iMemRead.
- Overflow: the edge on which TL=0xFFFF_FFFF with enable=1 loads TH and sets the status; oIRQ rises right after that edge.
- Timer period with TH=N: 2^32−N cycles between reloads.
- oScanClk is registered and glitch-free. Its first rising edge comes SCAN_DIV cycles after reset release.
- oDigits, oLeds, oIRQ, oInterrupt are direct register outputs with no combinational path from the bus.

## Structure
- Package periph_pkg holds:
  - address constants ADDR_TH, ADDR_TL, ADDR_TCON, ADDR_LED, ADDR_DIGITS, ADDR_SYSTICK;
  - TCON bit indices TCON_EN=0, TCON_IE=1, TCON_IS=2.
- Sub-module scan_clk_div(SCAN_DIV): contains the counter and oScanClk toggle flop. Instantiated once.
- Top-level contains the decode, register file, timer, and systick.

## Test plan
- Reset, then read all six addresses -> all return 0; oScanClk=0; oIRQ=0.
- SCAN_DIV=4 -> oScanClk toggles every 4 cycles. First rise is at cycle 4 after reset release; period is 8.
- TH=0xFFFF_FFFC, TL=0xFFFF_FFFE, TCON=3 -> TL reads 0xFFFF_FFFF next cycle. Following cycle TL=0xFFFF_FFFC and oIRQ=oInterrupt=1. Writing TCON=3 clears oIRQ one cycle later.
- Write TCON=3 in the exact overflow cycle -> bit 2 reads 1 afterward. Write TL=5 in the overflow cycle -> TL=5 and status set.
- Write DIGITS=0x1234_ABCD -> oDigits=0xABCD. Write LED=0x1FF -> oLeds=0xFF. Write 7 to 0x4000_0018 and to 0x4000_0011 -> no register changes; reads return 0.
- Assert reset_n=0 while the timer is running with oIRQ=1 -> next edge returns all registers to 0; SYSTICK restarts from 0 after release.
